// File: rtl/tb_mem_arbiter_pkg.sv
// Shared types for the two-client tb_memory arbiter.
// Command bundle, FSM encoding and client count.
package pkg_mem_arb;

  localparam int ARB_NUM_CLIENTS = 2;

  localparam logic SZ_8  = 1'b0;
  localparam logic SZ_16 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_GAP
  } arb_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        sz;
    logic        we;
    logic [7:0]  wdata8;
    logic [15:0] wdata16;
  } mem_cmd_t;

endpackage

// File: rtl/tb_mem_arbiter_rr_pick.sv
// Combinational grant selection for the two clients.
// Ties go to client 1 under fixed priority, else away from last_grant.
module mem_arb_rr_pick
  import pkg_mem_arb::*;
(
  input  logic [ARB_NUM_CLIENTS-1:0] req,
  input  logic                       last_grant,
  input  logic                       fixed_prio,
  output logic                       grant,
  output logic                       any_req
);

  always_comb begin
    any_req = |req;
    grant   = 1'b0;
    unique case (1'b1)
      &req:             grant = fixed_prio | ~last_grant;
      req[1] & ~req[0]: grant = 1'b1;
      default:          grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Serialises two clients onto one tb_memory port.
// One access per grant; registered ack/err pulse and read data.
module tb_mem_arbiter
  import pkg_mem_arb::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit FIXED_PRIO     = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      cl_req,
  input  logic [1:0][15:0] cl_addr,
  input  logic [1:0]      cl_sz,
  input  logic [1:0]      cl_we,
  input  logic [1:0][7:0] cl_wdata8,
  input  logic [1:0][15:0] cl_wdata16,
  output logic [1:0]      cl_ack,
  output logic [1:0]      cl_err,
  output logic [7:0]      rdata8,
  output logic [15:0]     rdata16,
  output logic            mem_req_rdwr,
  output logic [15:0]     mem_addr,
  output logic            mem_sz,
  output logic            mem_we8,
  output logic            mem_we16,
  output logic [7:0]      mem_wdata8,
  output logic [15:0]     mem_wdata16,
  input  logic [7:0]      mem_rdata8,
  input  logic [15:0]     mem_rdata16,
  input  logic            mem_data_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  arb_state_t    r_state;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  mem_cmd_t      r_cmd;
  logic          r_req;
  logic [1:0]    r_ack;
  logic [1:0]    r_err;
  logic [7:0]    r_rd8;
  logic [15:0]   r_rd16;

  logic     w_grant;
  logic     w_any;
  mem_cmd_t w_cmd;

  mem_arb_rr_pick u_pick (
    .req        (cl_req),
    .last_grant (r_last),
    .fixed_prio (FIXED_PRIO),
    .grant      (w_grant),
    .any_req    (w_any)
  );

  assign w_cmd = '{
    addr:    cl_addr[w_grant],
    sz:      cl_sz[w_grant],
    we:      cl_we[w_grant],
    wdata8:  cl_wdata8[w_grant],
    wdata16: cl_wdata16[w_grant]
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_req   <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      r_rd8   <= '0;
      r_rd16  <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_cmd   <= w_cmd;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_data_ready) begin
            if (!r_cmd.we) begin
              r_rd8  <= mem_rdata8;
              r_rd16 <= mem_rdata16;
            end
            r_ack[r_owner] <= 1'b1;
            r_req          <= 1'b0;
            r_last         <= r_owner;
            r_state        <= ARB_GAP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_err[r_owner] <= 1'b1;
            r_req          <= 1'b0;
            r_state        <= ARB_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // one idle cycle lets the memory drop data_ready
        ARB_GAP: r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign cl_ack       = r_ack;
  assign cl_err       = r_err;
  assign rdata8       = r_rd8;
  assign rdata16      = r_rd16;
  assign mem_req_rdwr = r_req;
  assign mem_addr     = r_cmd.addr;
  assign mem_sz       = r_cmd.sz;
  assign mem_we8      = r_cmd.we & (r_cmd.sz == SZ_8);
  assign mem_we16     = r_cmd.we & (r_cmd.sz == SZ_16);
  assign mem_wdata8   = r_cmd.wdata8;
  assign mem_wdata16  = r_cmd.wdata16;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Bench for tb_mem_arbiter: round-robin and fixed-priority instances,
// each on a behavioural memory with 1-2 cycle response.
module tb_tb_mem_arbiter;
  import pkg_mem_arb::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req   [2];
  logic [1:0][15:0] caddr [2];
  logic [1:0]       csz   [2];
  logic [1:0]       cwe   [2];
  logic [1:0][7:0]  cwd8  [2];
  logic [1:0][15:0] cwd16 [2];
  logic [1:0]       ack   [2];
  logic [1:0]       err   [2];
  logic [7:0]       rd8   [2];
  logic [15:0]      rd16  [2];
  logic             mreq  [2];
  logic [15:0]      maddr [2];
  logic             msz   [2];
  logic             mwe8  [2];
  logic             mwe16 [2];
  logic [7:0]       mwd8  [2];
  logic [15:0]      mwd16 [2];
  logic [7:0]       mrd8  [2];
  logic [15:0]      mrd16 [2];
  logic             mrdy  [2];

  tb_mem_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset_n(rst_n),
    .cl_req(req[0]), .cl_addr(caddr[0]), .cl_sz(csz[0]),
    .cl_we(cwe[0]), .cl_wdata8(cwd8[0]), .cl_wdata16(cwd16[0]),
    .cl_ack(ack[0]), .cl_err(err[0]),
    .rdata8(rd8[0]), .rdata16(rd16[0]),
    .mem_req_rdwr(mreq[0]), .mem_addr(maddr[0]), .mem_sz(msz[0]),
    .mem_we8(mwe8[0]), .mem_we16(mwe16[0]),
    .mem_wdata8(mwd8[0]), .mem_wdata16(mwd16[0]),
    .mem_rdata8(mrd8[0]), .mem_rdata16(mrd16[0]),
    .mem_data_ready(mrdy[0])
  );

  tb_mem_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset_n(rst_n),
    .cl_req(req[1]), .cl_addr(caddr[1]), .cl_sz(csz[1]),
    .cl_we(cwe[1]), .cl_wdata8(cwd8[1]), .cl_wdata16(cwd16[1]),
    .cl_ack(ack[1]), .cl_err(err[1]),
    .rdata8(rd8[1]), .rdata16(rd16[1]),
    .mem_req_rdwr(mreq[1]), .mem_addr(maddr[1]), .mem_sz(msz[1]),
    .mem_we8(mwe8[1]), .mem_we16(mwe16[1]),
    .mem_wdata8(mwd8[1]), .mem_wdata16(mwd16[1]),
    .mem_rdata8(mrd8[1]), .mem_rdata16(mrd16[1]),
    .mem_data_ready(mrdy[1])
  );

  logic [7:0] mem [2][65536];
  int  mcnt   [2] = '{0, 0};
  int  mlat   [2] = '{0, 0};
  int  w16cnt [2] = '{0, 0};
  bit  stub   [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!mreq[g]) begin
        mrdy[g] <= 1'b0;
        mcnt[g] <= 0;
        mlat[g] <= int'($urandom_range(1, 0));
      end else if (!mrdy[g] && !stub[g]) begin
        if (mcnt[g] >= mlat[g]) begin
          mrdy[g]  <= 1'b1;
          mrd8[g]  <= mem[g][maddr[g]];
          mrd16[g] <= {mem[g][maddr[g] + 16'd1], mem[g][maddr[g]]};
          if (mwe8[g]) mem[g][maddr[g]] <= mwd8[g];
          if (mwe16[g]) begin
            mem[g][maddr[g]]         <= mwd16[g][7:0];
            mem[g][maddr[g] + 16'd1] <= mwd16[g][15:8];
            w16cnt[g] <= w16cnt[g] + 1;
          end
        end else begin
          mcnt[g] <= mcnt[g] + 1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0]  rmem    [2][65536];
  logic        ref_last [2] = '{1'b1, 1'b1};
  logic [7:0]  ref_rd8  [2] = '{8'h0, 8'h0};
  logic [15:0] ref_rd16 [2] = '{16'h0, 16'h0};

  int          got_c [$];
  logic [7:0]  got8  [$];
  logic [15:0] got16 [$];
  int          n_err, n_rise, n_hi, first_hi;
  logic [15:0] last_maddr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_cmd_t mk(input logic [15:0] a, input logic s,
                                  input logic w, input logic [15:0] v);
    mem_cmd_t m;
    m.addr    = a;
    m.sz      = s;
    m.we      = w;
    m.wdata8  = v[7:0];
    m.wdata16 = v;
    return m;
  endfunction

  task automatic setcmd(input int d, input int c, input mem_cmd_t m);
    caddr[d][c] = m.addr;
    csz[d][c]   = m.sz;
    cwe[d][c]   = m.we;
    cwd8[d][c]  = m.wdata8;
    cwd16[d][c] = m.wdata16;
  endtask

  task automatic chk_zero(input int d);
    chk("rst_req", 32'(mreq[d]), 32'd0);
    chk("rst_ack", 32'(ack[d]), 32'd0);
    chk("rst_err", 32'(err[d]), 32'd0);
    chk("rst_rd8", 32'(rd8[d]), 32'd0);
    chk("rst_rd16", 32'(rd16[d]), 32'd0);
    chk("rst_addr", 32'(maddr[d]), 32'd0);
    chk("rst_we", 32'({mwe8[d], mwe16[d], msz[d]}), 32'd0);
    chk("rst_wd", 32'({mwd8[d], mwd16[d]}), 32'd0);
  endtask

  task automatic run(input int d, input logic [1:0] mask,
                     input mem_cmd_t c0, input mem_cmd_t c1);
    logic [1:0] pend;
    logic       prev;
    got_c.delete();
    got8.delete();
    got16.delete();
    n_err = 0; n_rise = 0; n_hi = 0; first_hi = -1;
    setcmd(d, 0, c0);
    setcmd(d, 1, c1);
    req[d] = mask;
    pend   = mask;
    prev   = mreq[d];
    for (int cy = 0; cy < 64 && pend != 2'b00; cy++) begin
      @(negedge clk);
      if (mreq[d]) begin
        n_hi++;
        last_maddr = maddr[d];
        if (first_hi < 0) first_hi = cy;
        if (!prev) n_rise++;
      end
      prev = mreq[d];
      for (int c = 0; c < 2; c++) begin
        if (ack[d][c]) begin
          got_c.push_back(c);
          got8.push_back(rd8[d]);
          got16.push_back(rd16[d]);
          pend[c] = 1'b0;
          req[d][c] = 1'b0;
        end
        if (err[d][c]) begin
          n_err++;
          pend[c] = 1'b0;
          req[d][c] = 1'b0;
        end
      end
    end
    chk("run_done", 32'(pend), 32'd0);
    req[d] = 2'b00;
  endtask

  task automatic check_run(input int d, input logic [1:0] mask,
                           input mem_cmd_t c0, input mem_cmd_t c1);
    int       ord [$];
    int       first;
    int       c;
    mem_cmd_t cm;
    if (mask == 2'b11) begin
      first = (d == 1) ? 1 : (ref_last[d] ? 0 : 1);
      ord.push_back(first);
      ord.push_back(1 - first);
    end else begin
      ord.push_back(mask[1] ? 1 : 0);
    end
    chk("ack_count", 32'(got_c.size()), 32'(ord.size()));
    chk("err_count", 32'(n_err), 32'd0);
    for (int i = 0; i < ord.size(); i++) begin
      c  = ord[i];
      cm = (c == 1) ? c1 : c0;
      if (cm.we) begin
        if (cm.sz == SZ_16) begin
          rmem[d][cm.addr]         = cm.wdata16[7:0];
          rmem[d][cm.addr + 16'd1] = cm.wdata16[15:8];
        end else begin
          rmem[d][cm.addr] = cm.wdata8;
        end
      end else begin
        ref_rd8[d]  = rmem[d][cm.addr];
        ref_rd16[d] = {rmem[d][cm.addr + 16'd1], rmem[d][cm.addr]};
      end
      ref_last[d] = (c == 1);
      if (i < got_c.size()) begin
        chk("grant_order", 32'(got_c[i]), 32'(c));
        chk("rdata8", 32'(got8[i]), 32'(ref_rd8[d]));
        chk("rdata16", 32'(got16[i]), 32'(ref_rd16[d]));
      end
    end
  endtask

  task automatic xact(input int d, input logic [1:0] mask,
                      input mem_cmd_t c0, input mem_cmd_t c1);
    run(d, mask, c0, c1);
    check_run(d, mask, c0, c1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem_cmd_t    idle;
    mem_cmd_t    ca;
    mem_cmd_t    cb;
    int          seq [$];
    int          w16_before;
    int          k;
    bit          seen_ack;
    int          n1;
    int          t_prev;
    bit          got0;
    logic [15:0] pool [8];
    logic [1:0]  m;

    idle = mk(16'h0, SZ_8, 1'b0, 16'h0);
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00;
      setcmd(d, 0, idle);
      setcmd(d, 1, idle);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 2'b01, mk(16'h0010, SZ_16, 1'b1, 16'h005A), idle);
    repeat (2) @(negedge clk);
    xact(0, 2'b01, mk(16'h0010, SZ_8, 1'b0, 16'h0), idle);
    chk("single_rd8", 32'(got8.size() > 0 ? got8[0] : 8'h0), 32'h5A);
    chk("single_rises", 32'(n_rise), 32'd1);
    chk("single_busy_len", 32'(n_hi >= 2 && n_hi <= 3), 32'd1);
    chk("req_latency", 32'(first_hi), 32'd0);

    w16_before = w16cnt[0];
    xact(0, 2'b10, idle, mk(16'h0100, SZ_16, 1'b1, 16'hBEEF));
    chk("w16_log", 32'(w16cnt[0] - w16_before), 32'd1);
    xact(0, 2'b10, idle, mk(16'h0100, SZ_16, 1'b0, 16'h0));
    chk("readback16", 32'(rd16[0]), 32'hBEEF);

    ca = mk(16'h0010, SZ_8, 1'b0, 16'h0);
    cb = mk(16'h0100, SZ_16, 1'b0, 16'h0);
    for (int r = 0; r < 2; r++) begin
      xact(0, 2'b11, ca, cb);
      foreach (got_c[i]) seq.push_back(got_c[i]);
    end
    chk("contend_len", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk("contend_alt", 32'(seq[i]), 32'(i % 2));

    xact(0, 2'b01, mk(16'hFFFF, SZ_16, 1'b1, 16'h1234), idle);
    chk("addr_ffff", 32'(last_maddr), 32'hFFFF);
    xact(0, 2'b01, mk(16'hFFFF, SZ_16, 1'b0, 16'h0), idle);

    stub[0] = 1'b1;
    repeat (2) @(negedge clk);
    setcmd(0, 0, mk(16'h0010, SZ_8, 1'b0, 16'h0));
    req[0] = 2'b01;
    k = -1;
    seen_ack = 1'b0;
    for (int cy = 0; cy < 40; cy++) begin
      @(negedge clk);
      if (mreq[0] && k < 0) k = 0;
      else if (k >= 0) k++;
      if (ack[0] != 2'b00) seen_ack = 1'b1;
      if (err[0] != 2'b00) break;
    end
    chk("timeout_cycles", 32'(k), 32'd16);
    chk("timeout_err", 32'(err[0]), 32'd1);
    chk("timeout_req_low", 32'(mreq[0]), 32'd0);
    chk("timeout_noack", 32'(seen_ack), 32'd0);
    chk("timeout_rdata", 32'(rd16[0]), 32'(ref_rd16[0]));
    req[0] = 2'b00;
    stub[0] = 1'b0;
    xact(0, 2'b01, mk(16'h0010, SZ_8, 1'b0, 16'h0), idle);

    stub[0] = 1'b1;
    setcmd(0, 1, mk(16'h0100, SZ_16, 1'b0, 16'h0));
    req[0] = 2'b10;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(mreq[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    for (int d = 0; d < 2; d++) begin
      ref_last[d] = 1'b1;
      ref_rd8[d]  = 8'h0;
      ref_rd16[d] = 16'h0;
    end
    stub[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 2'b11, ca, cb);
    chk("post_reset_first", 32'(got_c.size() > 0 ? got_c[0] : 9), 32'd0);

    xact(1, 2'b01, mk(16'h0020, SZ_16, 1'b1, 16'hA55A), idle);
    setcmd(1, 0, mk(16'h0020, SZ_8, 1'b0, 16'h0));
    setcmd(1, 1, mk(16'h0020, SZ_16, 1'b0, 16'h0));
    req[1] = 2'b11;
    n1 = 0;
    t_prev = -1;
    for (int cy = 0; cy < 80 && n1 < 4; cy++) begin
      @(negedge clk);
      if (ack[1] != 2'b00) begin
        chk("fp_client1", 32'(ack[1]), 32'd2);
        chk("fp_rd16", 32'(rd16[1]), 32'hA55A);
        // BUSY is 2-3 cycles with this memory, plus GAP and IDLE
        if (t_prev >= 0)
          chk("fp_spacing", 32'((cy - t_prev) >= 4 && (cy - t_prev) <= 5), 32'd1);
        t_prev = cy;
        n1++;
      end
    end
    chk("fp_count", 32'(n1), 32'd4);
    req[1][1] = 1'b0;
    got0 = 1'b0;
    for (int cy = 0; cy < 20 && !got0; cy++) begin
      @(negedge clk);
      if (ack[1] != 2'b00) begin
        chk("fp_then_c0", 32'(ack[1]), 32'd1);
        chk("fp_c0_rd8", 32'(rd8[1]), 32'h5A);
        got0 = 1'b1;
        req[1][0] = 1'b0;
      end
    end
    chk("fp_c0_served", 32'(got0), 32'd1);
    req[1] = 2'b00;

    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'h0400 + 16'(i * 4);
      xact(0, 2'b01, mk(pool[i], SZ_16, 1'b1, 16'($urandom)), idle);
    end
    for (int it = 0; it < 30; it++) begin
      m  = 2'($urandom_range(3, 1));
      ca = mk(pool[$urandom_range(7, 0)], 1'($urandom),
              ($urandom_range(2, 0) == 0), 16'($urandom));
      cb = mk(pool[$urandom_range(7, 0)], 1'($urandom),
              ($urandom_range(2, 0) == 0), 16'($urandom));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      xact(0, m, ca, cb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
